// File: rtl/jtgaiden_wildfang_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtgaiden_wildfang_pkg
//  Purpose  : Shared constants and state encoding for the Wild Fang protection
//  Revision : 1.0 - initial release
// ============================================================================
package jtgaiden_wildfang_pkg;

  localparam int JUMP_CNT = 17;

  localparam logic [3:0] CMD_RST = 4'h0;
  localparam logic [3:0] CMD_HI  = 4'h1;
  localparam logic [3:0] CMD_LO  = 4'h2;
  localparam logic [3:0] CMD_N3  = 4'h3;
  localparam logic [3:0] CMD_N2  = 4'h4;
  localparam logic [3:0] CMD_N1  = 4'h5;
  localparam logic [3:0] CMD_N0  = 4'h6;

  typedef enum logic [1:0] {
    READY = 2'd0,
    WAIT  = 2'd1,
    CAPT  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/jtgaiden_wildfang_prot.sv
`default_nettype none
// ============================================================================
//  Module   : jtgaiden_wildfang_prot
//  Purpose  : Protection-MCU replacement: command decode, jump fetch, nibble read
//  Revision : 1.0 - initial release
// ============================================================================
module jtgaiden_wildfang_prot #(
  parameter int JUMP_CNT = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prot_we,
  input  logic [7:0]  prot_din,
  output logic [7:0]  prot_dout,
  output logic [4:0]  lut_addr,
  input  logic [15:0] lut_jump,
  output logic        err
);
  import jtgaiden_wildfang_pkg::*;

  localparam logic [5:0] c_jump_lim = JUMP_CNT[5:0];

  state_t      r_state, w_state_nx;
  logic        r_we_l;
  logic        r_pend_v, w_pend_v_nx;
  logic [7:0]  r_pend, w_pend_nx;
  logic [4:0]  r_code, w_code_nx;
  logic [15:0] r_jump, w_jump_nx;
  logic        r_err, w_err_nx;
  logic [7:0]  r_dout, w_dout_nx;

  logic        w_ev;
  logic        w_exec_v;
  logic [7:0]  w_exec_byte;
  logic [3:0]  w_cmd;
  logic [3:0]  w_arg;
  logic [3:0]  w_nib;

  assign w_ev  = prot_we & ~r_we_l;
  assign w_cmd = w_exec_byte[7:4];
  assign w_arg = w_exec_byte[3:0];

  always_comb begin
    w_state_nx  = r_state;
    w_pend_v_nx = r_pend_v;
    w_pend_nx   = r_pend;
    w_code_nx   = r_code;
    w_jump_nx   = r_jump;
    w_err_nx    = r_err;
    w_dout_nx   = r_dout;
    w_exec_v    = 1'b0;
    w_exec_byte = prot_din;
    w_nib       = 4'h0;

    // A pending command takes priority; a new event arriving alongside it is parked.
    case (r_state)
      READY: begin
        w_exec_v    = r_pend_v | w_ev;
        w_exec_byte = r_pend_v ? r_pend : prot_din;
        w_pend_v_nx = r_pend_v & w_ev;
        if (w_ev) w_pend_nx = prot_din;
      end
      WAIT: begin
        w_state_nx = CAPT;
        if (w_ev) begin
          w_pend_v_nx = 1'b1;
          w_pend_nx   = prot_din;
        end
      end
      CAPT: begin
        w_state_nx = READY;
        w_jump_nx  = r_err ? 16'h0000 : lut_jump;
        if (w_ev) begin
          w_pend_v_nx = 1'b1;
          w_pend_nx   = prot_din;
        end
      end
      default: w_state_nx = READY;
    endcase

    case (w_cmd)
      CMD_N3:  w_nib = r_jump[15:12];
      CMD_N2:  w_nib = r_jump[11:8];
      CMD_N1:  w_nib = r_jump[7:4];
      default: w_nib = r_jump[3:0];
    endcase

    if (w_exec_v) begin
      case (w_cmd)
        CMD_RST: begin
          w_dout_nx = 8'h00;
          w_err_nx  = 1'b0;
          w_code_nx = 5'd0;
        end
        CMD_HI: begin
          w_code_nx = {w_arg[0], r_code[3:0]};
          w_dout_nx = 8'h10;
        end
        CMD_LO: begin
          w_code_nx  = {r_code[4], w_arg};
          w_dout_nx  = 8'h20;
          w_err_nx   = ({1'b0, r_code[4], w_arg} >= c_jump_lim);
          w_state_nx = WAIT;
        end
        CMD_N3, CMD_N2, CMD_N1, CMD_N0: begin
          w_dout_nx = {w_cmd + 4'd1, w_nib};
        end
        default: ;
      endcase
    end
  end

  // The edge detector keeps tracking the strobe through reset so a held
  // strobe across reset release is not mistaken for a new write.
  always_ff @(posedge clk) begin
    r_we_l <= prot_we;
    if (rst) begin
      r_state  <= READY;
      r_pend_v <= 1'b0;
      r_pend   <= 8'h00;
      r_code   <= 5'd0;
      r_jump   <= 16'h0000;
      r_err    <= 1'b0;
      r_dout   <= 8'h00;
    end else begin
      r_state  <= w_state_nx;
      r_pend_v <= w_pend_v_nx;
      r_pend   <= w_pend_nx;
      r_code   <= w_code_nx;
      r_jump   <= w_jump_nx;
      r_err    <= w_err_nx;
      r_dout   <= w_dout_nx;
    end
  end

  assign prot_dout = r_dout;
  assign lut_addr  = r_code;
  assign err       = r_err;

endmodule
`default_nettype wire
